// File: rtl/logical_tile_io_pi_mode_io_pi_capture.sv
// ASIC-to-fabric input pad capture for the io_pi tile.
// The raw pad level reaches the fabric either through a combinational bypass,
// or through a synchronizer, a glitch filter and an edge detector. The capture
// flops (sync stages, filtered level, edge flop) double as a scan chain that
// runs sc_in -> sync0 -> sync1 -> filt -> edge -> sc_out.
module logical_tile_io_pi_mode_io_pi_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic       io_pi_clk,
    input  logic       io_pi_resetb,
    input  logic       SE0,
    input  logic       gfpga_pad_pinput_A2F,
    input  logic       io_pi_sc_in,
    input  logic [0:7] feedthrough_mem_in,
    input  logic [0:7] feedthrough_mem_inb,
    output logic       io_pi_a2f_o,
    output logic       io_pi_edge_o,
    output logic       io_pi_sc_out
);

    // Configuration fields; the threshold slice keeps mem_in[2] as its MSB.
    logic             mode_s;
    logic             inv_s;
    logic [CNT_W-1:0] n_s;
    logic             rise_en_s;
    logic             fall_en_s;
    logic             cfg_unused_s;

    assign mode_s       = feedthrough_mem_in[0];
    assign inv_s        = feedthrough_mem_in[1];
    assign n_s          = feedthrough_mem_in[2:5];
    assign rise_en_s    = feedthrough_mem_in[6];
    assign fall_en_s    = feedthrough_mem_in[7];
    // The complement bits only exist so the config chain stays uniform.
    assign cfg_unused_s = ^feedthrough_mem_inb;

    // State: sync_r[0] is the pad-facing stage, sync_r[SYNC_STAGES-1] feeds the filter.
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   filt_r;
    logic                   edge_r;
    logic [CNT_W-1:0]       cnt_r;

    // Next-state signals of the filter and edge detector.
    logic                   sync_last_s;
    logic [CNT_W-1:0]       thr_s;
    logic                   diff_s;
    logic                   upd_s;
    logic                   new_lvl_s;
    logic                   edge_nxt_s;
    logic [CNT_W-1:0]       cnt_nxt_s;

    assign sync_last_s = sync_r[SYNC_STAGES-1];

    // Filter decision: a threshold of 0 behaves like 1, and the >= compare
    // lets a lowered threshold take effect on the very next differing edge.
    always_comb begin
        thr_s      = {CNT_W{1'b0}};
        diff_s     = 1'b0;
        upd_s      = 1'b0;
        new_lvl_s  = 1'b0;
        edge_nxt_s = 1'b0;
        cnt_nxt_s  = {CNT_W{1'b0}};

        if (n_s == {CNT_W{1'b0}}) begin
            thr_s = {CNT_W{1'b0}};
        end else begin
            thr_s = n_s - {{(CNT_W-1){1'b0}}, 1'b1};
        end

        diff_s    = (sync_last_s != filt_r);
        upd_s     = diff_s && (cnt_r >= thr_s);
        // Polarity is judged on the level the fabric will actually see.
        new_lvl_s = sync_last_s ^ inv_s;
        edge_nxt_s = upd_s && ((new_lvl_s && rise_en_s) || (!new_lvl_s && fall_en_s));

        if (!diff_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (upd_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Capture flops: scan shift takes priority over functional capture; the
    // functional path keeps clocking in bypass mode so a mode switch is seamless.
    always_ff @(posedge io_pi_clk or negedge io_pi_resetb) begin
        if (!io_pi_resetb) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            filt_r <= 1'b0;
            edge_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (SE0) begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], io_pi_sc_in};
            filt_r <= sync_last_s;
            edge_r <= filt_r;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], gfpga_pad_pinput_A2F};
            if (upd_s) begin
                filt_r <= sync_last_s;
            end else begin
                filt_r <= filt_r;
            end
            edge_r <= edge_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    // Output path select is combinational so bypass has zero latency.
    assign io_pi_a2f_o  = mode_s ? (filt_r ^ inv_s) : (gfpga_pad_pinput_A2F ^ inv_s);
    assign io_pi_edge_o = edge_r & mode_s & ~SE0;
    assign io_pi_sc_out = edge_r;

endmodule

// File: tb/tb_logical_tile_io_pi_mode_io_pi_capture.sv
// Directed bench for the io_pi capture tile. A behavioural model tracks the
// pad as seen two edges late, counts how many consecutive edges it has
// disagreed with the filtered level, and treats the four flops as a plain
// shift register while scanning. A compare process checks every cycle; the
// directed sections add hand-computed literal expectations.
module tb_logical_tile_io_pi_mode_io_pi_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       se = 1'b0;
    logic       pad = 1'b0;
    logic       sc_in = 1'b0;
    logic       mode = 1'b0;
    logic       inv = 1'b0;
    logic [3:0] nthr = 4'd0;
    logic       rise = 1'b0;
    logic       fall = 1'b0;
    logic [0:7] cfg;
    logic       a2f_o;
    logic       edge_o;
    logic       sc_out;

    int n_checks = 0;
    int n_errors = 0;

    assign cfg = {mode, inv, nthr, rise, fall};

    logical_tile_io_pi_mode_io_pi_capture dut (
        .io_pi_clk            (clk),
        .io_pi_resetb         (rst_n),
        .SE0                  (se),
        .gfpga_pad_pinput_A2F (pad),
        .io_pi_sc_in          (sc_in),
        .feedthrough_mem_in   (cfg),
        .feedthrough_mem_inb  (~cfg),
        .io_pi_a2f_o          (a2f_o),
        .io_pi_edge_o         (edge_o),
        .io_pi_sc_out         (sc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s0;
        logic       s1;
        logic       filt;
        logic       edg;
        logic [7:0] streak;
    } mstate_t;

    mstate_t m = '0;

    // One clock edge of the model: the filtered level follows the delayed pad
    // once it has disagreed for N edges in a row (N=0 acts as 1).
    function automatic mstate_t model_step(input mstate_t cur, input logic scan,
                                           input logic sin, input logic p,
                                           input logic [3:0] n, input logic iv,
                                           input logic re, input logic fe);
        mstate_t nx;
        int need;
        logic lvl;
        nx = cur;
        if (scan) begin
            nx.edg    = cur.filt;
            nx.filt   = cur.s1;
            nx.s1     = cur.s0;
            nx.s0     = sin;
            nx.streak = 8'd0;
        end else begin
            need = (n == 4'd0) ? 1 : int'(n);
            nx.edg = 1'b0;
            if (cur.s1 != cur.filt) begin
                if (int'(cur.streak) + 1 >= need) begin
                    nx.filt   = cur.s1;
                    nx.streak = 8'd0;
                    lvl       = cur.s1 ^ iv;
                    nx.edg    = (lvl && re) || (!lvl && fe);
                end else begin
                    nx.streak = cur.streak + 8'd1;
                end
            end else begin
                nx.streak = 8'd0;
            end
            nx.s1 = cur.s0;
            nx.s0 = p;
        end
        return nx;
    endfunction

    // Model state advance, cleared asynchronously like the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, se, sc_in, pad, nthr, inv, rise, fall);
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_a2f", a2f_o, mode ? (m.filt ^ inv) : (pad ^ inv));
        check("model_edge", edge_o, m.edg & mode & ~se);
        check("model_sc_out", sc_out, m.edg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] pat;
    logic [7:0] sc_exp;

    initial begin
        // 1: bypass follows the pad combinationally, in and out of reset
        mode = 1'b0; inv = 1'b1; pad = 1'b0;
        rst_n = 1'b0;
        #1;
        check("byp_rst_a2f_lo", a2f_o, 1'b1);
        check("byp_rst_edge", edge_o, 1'b0);
        check("byp_rst_sc", sc_out, 1'b0);
        pad = 1'b1; #1;
        check("byp_rst_a2f_hi", a2f_o, 1'b0);
        tick(); tick();
        check("byp_rst_a2f_hold", a2f_o, 1'b0);
        rst_n = 1'b1;
        tick();
        pad = 1'b0; #1;
        check("byp_a2f_lo", a2f_o, 1'b1);
        tick();
        check("byp_edge", edge_o, 1'b0);
        pad = 1'b1; #1;
        check("byp_a2f_hi", a2f_o, 1'b0);

        // 2: registered latency with N=0
        mode = 1'b1; inv = 1'b0; nthr = 4'd0; rise = 1'b1; fall = 1'b0; pad = 1'b0;
        rst_n = 1'b0; #1;
        check("reg_rst_a2f", a2f_o, 1'b0);
        check("reg_rst_edge", edge_o, 1'b0);
        check("reg_rst_sc", sc_out, 1'b0);
        tick();
        rst_n = 1'b1;
        pad = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("lat_a2f", a2f_o, (e >= 3) ? 1'b1 : 1'b0);
            check("lat_edge", edge_o, (e == 3) ? 1'b1 : 1'b0);
        end

        // 3: glitch filter with N=4
        pad = 1'b0; nthr = 4'd4;
        do_reset();
        pad = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) pad = 1'b0;
            tick();
            check("glitch_a2f", a2f_o, 1'b0);
            check("glitch_edge", edge_o, 1'b0);
        end
        pad = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            if (e == 6) pad = 1'b0;
            tick();
            check("filt_a2f", a2f_o, (e >= 6) ? 1'b1 : 1'b0);
            check("filt_edge", edge_o, (e == 6) ? 1'b1 : 1'b0);
        end
        for (int e = 1; e <= 5; e++) tick();

        // 4: falling-edge select, then same with inverted output
        pad = 1'b0; nthr = 4'd1; rise = 1'b0; fall = 1'b1; inv = 1'b0;
        do_reset();
        pad = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) pad = 1'b0;
            tick();
            check("fsel_edge", edge_o, (e == 7) ? 1'b1 : 1'b0);
        end
        pad = 1'b0; inv = 1'b1;
        do_reset();
        pad = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) pad = 1'b0;
            tick();
            check("fsel_inv_edge", edge_o, (e == 3) ? 1'b1 : 1'b0);
            check("fsel_inv_a2f", a2f_o, (e >= 3 && e <= 6) ? 1'b0 : 1'b1);
        end

        // 5: scan shift of 1,0,1,1 over known contents {s0,s1,filt,edge}={1,1,1,0}
        pad = 1'b0; inv = 1'b0; rise = 1'b1; fall = 1'b0; nthr = 4'd1;
        do_reset();
        pad = 1'b1;
        for (int e = 1; e <= 6; e++) tick();
        pad = 1'b0; se = 1'b1; #1;
        check("scan_orig_sc", sc_out, 1'b0);
        pat    = 8'b1011_0000;
        sc_exp = 8'b1111_0110;
        for (int i = 0; i < 8; i++) begin
            sc_in = pat[7-i];
            tick();
            check("scan_sc_out", sc_out, sc_exp[7-i]);
            check("scan_edge", edge_o, 1'b0);
        end
        sc_in = 1'b0; se = 1'b0; nthr = 4'd2; pad = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("post_scan_a2f", a2f_o, (e >= 4) ? 1'b1 : 1'b0);
            check("post_scan_edge", edge_o, (e == 4) ? 1'b1 : 1'b0);
        end

        // 6: async reset in the middle of an N=8 count
        pad = 1'b0; nthr = 4'd8; inv = 1'b1; rise = 1'b1; fall = 1'b1;
        do_reset();
        pad = 1'b1;
        for (int e = 1; e <= 7; e++) tick();
        check("mid_a2f_before", a2f_o, 1'b1);
        #2;
        rst_n = 1'b0; #1;
        check("mid_rst_a2f", a2f_o, 1'b1);
        check("mid_rst_edge", edge_o, 1'b0);
        check("mid_rst_sc", sc_out, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            check("mid_restart_a2f", a2f_o, (e >= 10) ? 1'b0 : 1'b1);
            check("mid_restart_edge", edge_o, (e == 10) ? 1'b1 : 1'b0);
        end

        // mode switch mid-operation: output path flips, flops untouched
        mode = 1'b0; #1;
        check("mode_byp_a2f", a2f_o, 1'b0);
        pad = 1'b0; #1;
        check("mode_byp_a2f2", a2f_o, 1'b1);
        tick();
        mode = 1'b1; #1;
        check("mode_reg_a2f", a2f_o, 1'b0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
